// File: rtl/bool_mask_split_pkg.sv
// Shared definitions for the Boolean masking encoder and the matching
// unmasking stage. It holds the randomness budget, the share slicing helper
// and the share-count sanity check.
package bool_mask_split_pkg;

  localparam int K_WIDTH_DEF  = 32;
  localparam int N_SHARES_DEF = 3;

  // Randomness words per input word: N-1 for the split, N-1 for the refresh.
  function automatic int randnum(input int n_shares);
    return 2 * (n_shares - 1);
  endfunction

  // Bit offset of word/share idx inside a packed bus of k-bit words.
  function automatic int share_off(input int idx, input int k);
    return idx * k;
  endfunction

  // With fewer than two shares the value would sit unmasked on the bus.
  function automatic bit n_shares_ok(input int n_shares);
    return n_shares >= 2;
  endfunction

endpackage

// File: rtl/bool_mask_split_if.sv
// Input, randomness and output handshakes of the masking encoder.
// The slave side is the encoder. The master side is whoever feeds it and
// drains it.
interface bool_mask_split_if
  import bool_mask_split_pkg::*;
#(
  parameter int K_WIDTH  = K_WIDTH_DEF,
  parameter int N_SHARES = N_SHARES_DEF
);
  localparam int MASKWIDTH = K_WIDTH * N_SHARES;
  localparam int RANDNUM   = randnum(N_SHARES);

  logic                         dvld;
  logic [K_WIDTH-1:0]           i_x;
  logic                         i_rdy;
  logic [K_WIDTH*RANDNUM-1:0]   rnd;
  logic                         rnd_vld;
  logic                         rnd_rdy;
  logic [MASKWIDTH-1:0]         o_x;
  logic                         ovld;
  logic                         o_rdy;

  modport master (
    output dvld, i_x, rnd, rnd_vld, o_rdy,
    input  i_rdy, rnd_rdy, o_x, ovld
  );

  modport slave (
    input  dvld, i_x, rnd, rnd_vld, o_rdy,
    output i_rdy, rnd_rdy, o_x, ovld
  );
endinterface

// File: rtl/bool_mask_stage.sv
// One pipeline register stage. It holds a data word and a valid bit, and it
// moves only when both the global enable and the stage advance are high.
// Data loads only with a valid word, so a bubble leaves the old payload in
// place. That payload is don't-care while valid is low.
module bool_mask_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         adv,
  input  logic         vin,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  // Synchronous clear. Otherwise the stage advances on ena & adv.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (ena && adv) begin
      vld <= vin;
      if (vin) q <= d;
    end
  end

endmodule

// File: rtl/bool_mask_split.sv
// Boolean masking encoder. It splits an unmasked word into N_SHARES shares
// with fresh randomness (stage A), applies one chained refresh layer
// (stage B), and presents the packed shares on a valid/ready output.
// The XOR of all shares equals the input after each stage.
module bool_mask_split
  import bool_mask_split_pkg::*;
#(
  parameter int K_WIDTH   = K_WIDTH_DEF,
  parameter int N_SHARES  = N_SHARES_DEF,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES,
  parameter int RANDNUM   = randnum(N_SHARES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  bool_mask_split_if.slave  bus
);

  localparam int NR   = N_SHARES - 1;       // words per split / per refresh
  localparam int RW   = K_WIDTH * NR;       // refresh words carried in stage A
  localparam int A_W  = MASKWIDTH + RW;

  if (!n_shares_ok(N_SHARES)) begin : g_bad_shares
    $error("bool_mask_split: N_SHARES must be >= 2");
  end

  logic [RANDNUM-1:0][K_WIDTH-1:0]  rw;
  logic [N_SHARES-1:0][K_WIDTH-1:0] split_sh, a_sh, ref_sh;
  logic [NR-1:0][K_WIDTH-1:0]       split_r, a_r;
  logic [A_W-1:0]                   a_d, a_q;
  logic [MASKWIDTH-1:0]             b_q;
  logic                             va, vb, adv_a, adv_b, acc;

  // Unpack the randomness bus word by word.
  for (genvar j = 0; j < RANDNUM; j++) begin : g_rnd
    assign rw[j] = bus.rnd[share_off(j, K_WIDTH) +: K_WIDTH];
  end

  // Each stage moves when its successor has room. Data and randomness are
  // taken together, so each ready depends on the other side's valid.
  assign adv_b       = ~vb | bus.o_rdy;
  assign adv_a       = ~va | adv_b;
  assign acc         = ena & adv_a & bus.dvld & bus.rnd_vld;
  assign bus.i_rdy   = ena & adv_a & bus.rnd_vld;
  assign bus.rnd_rdy = ena & adv_a & bus.dvld;

  // Split: shares 1..N-1 are raw random words, and share 0 absorbs them all.
  always_comb begin
    split_sh    = '0;
    split_sh[0] = bus.i_x;
    for (int i = 1; i < N_SHARES; i++) begin
      split_sh[i] = rw[i-1];
      split_sh[0] = split_sh[0] ^ rw[i-1];
    end
  end

  // The refresh words ride through stage A with the shares. No randomness
  // is sampled after the accept.
  always_comb begin
    split_r = '0;
    for (int j = 0; j < NR; j++) split_r[j] = rw[NR + j];
  end

  assign a_d = {split_r, split_sh};

  bool_mask_stage #(.W(A_W)) u_stage_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .adv   (adv_a),
    .vin   (acc),
    .d     (a_d),
    .vld   (va),
    .q     (a_q)
  );

  assign {a_r, a_sh} = a_q;

  // Chained refresh: word j goes into shares j and j+1, so it cancels in
  // the XOR of all shares.
  always_comb begin
    ref_sh = a_sh;
    for (int j = 0; j < NR; j++) begin
      ref_sh[j]   = ref_sh[j]   ^ a_r[j];
      ref_sh[j+1] = ref_sh[j+1] ^ a_r[j];
    end
  end

  bool_mask_stage #(.W(MASKWIDTH)) u_stage_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .adv   (adv_b),
    .vin   (va),
    .d     (ref_sh),
    .vld   (vb),
    .q     (b_q)
  );

  assign bus.ovld = vb;
  assign bus.o_x  = b_q;

endmodule
